datapath_core: RTL and testbench

Single-bus 32-bit CPU datapath for the phase-1 RISC processor. Sixteen general registers, HI/LO, PC, IR, MAR, MDR, the ALU operand register Y and the 64-bit ALU result register Z all share one internal bus. An external control unit or testbench drives one-hot register-out selects, per-register load enables and an ALU opcode each clock. This block contains no instruction decoding or sequencing.

---
 rtl/datapath_core.sv | 114 +++++++++++
 tb/tb_datapath_core.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/datapath_core.sv
// Single-bus 32-bit datapath: 16 GPRs, HI/LO, PC, IR, MAR, MDR, Y and 64-bit Z around one shared bus.
// Bus and ALU are combinational; every register loads on the rising edge of clk; clr clears all.
module datapath_core (
  input  logic        clk,
  input  logic        clr,
  input  logic        R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out,
  input  logic        R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out,
  input  logic        HIout, LOout, Zhighout, Zlowout, PCout, MDRout,
  input  logic        R0in, R1in, R2in, R3in, R4in, R5in, R6in, R7in,
  input  logic        R8in, R9in, R10in, R11in, R12in, R13in, R14in, R15in,
  input  logic        HIin, LOin, PCin, IRin, MARin, MDRin, Yin, Zin,
  input  logic        Read,
  input  logic [4:0]  OpCode,
  input  logic [31:0] Mdatain,
  output logic [31:0] BusMuxOut,
  output logic [31:0] IRout_q,
  output logic [31:0] MARout_q
);

  logic [15:0] r_out, r_in;
  logic [31:0] r_q [16];
  logic [31:0] hi_q, lo_q, pc_q, ir_q, mar_q, mdr_q, y_q;
  logic [63:0] z_q;
  logic [31:0] bus;
  logic [31:0] mdr_d;
  logic [63:0] z_d;

  assign r_out = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                  R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};
  assign r_in  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                  R7in, R6in, R5in, R4in, R3in, R2in, R1in, R0in};

  // Later assignments override earlier ones, so the lowest-listed source wins.
  always_comb begin
    bus = '0;
    if (MDRout)   bus = mdr_q;
    if (PCout)    bus = pc_q;
    if (Zlowout)  bus = z_q[31:0];
    if (Zhighout) bus = z_q[63:32];
    if (LOout)    bus = lo_q;
    if (HIout)    bus = hi_q;
    for (int i = 15; i >= 0; i--) begin
      if (r_out[i]) bus = r_q[i];
    end
  end

  assign BusMuxOut = bus;
  assign IRout_q   = ir_q;
  assign MARout_q  = mar_q;
  assign mdr_d     = Read ? Mdatain : bus;

  logic [4:0]         sh;
  logic [63:0]        rot_r, rot_l;
  logic signed [63:0] prod;
  logic signed [31:0] quo, rem;

  always_comb begin
    sh    = bus[4:0];
    rot_r = {y_q, y_q} >> sh;
    rot_l = {y_q, y_q} << sh;
    prod  = $signed({{32{y_q[31]}}, y_q}) * $signed({{32{bus[31]}}, bus});
    quo   = '0;
    rem   = '0;
    if (bus != '0) begin
      quo = $signed(y_q) / $signed(bus);
      rem = $signed(y_q) % $signed(bus);
    end
    z_d = '0;
    case (OpCode)
      5'd0:    z_d[31:0] = y_q | bus;
      5'd1:    z_d[31:0] = y_q & bus;
      5'd2:    z_d[31:0] = y_q + bus;
      5'd3:    z_d[31:0] = y_q - bus;
      5'd4:    z_d[31:0] = y_q >> sh;
      5'd5:    z_d[31:0] = $signed(y_q) >>> sh;
      5'd6:    z_d[31:0] = y_q << sh;
      5'd7:    z_d[31:0] = rot_r[31:0];
      5'd8:    z_d[31:0] = rot_l[63:32];
      5'd9:    z_d       = prod;
      5'd10:   z_d       = {rem, quo};
      5'd11:   z_d[31:0] = -bus;
      5'd12:   z_d[31:0] = bus + 32'd1;
      5'd13:   z_d[31:0] = ~bus;
      default: z_d       = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 16; i++) r_q[i] <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      pc_q  <= '0;
      ir_q  <= '0;
      mar_q <= '0;
      mdr_q <= '0;
      y_q   <= '0;
      z_q   <= '0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (r_in[i]) r_q[i] <= bus;
      end
      if (HIin)  hi_q  <= bus;
      if (LOin)  lo_q  <= bus;
      if (PCin)  pc_q  <= bus;
      if (IRin)  ir_q  <= bus;
      if (MARin) mar_q <= bus;
      if (MDRin) mdr_q <= mdr_d;
      if (Yin)   y_q   <= bus;
      if (Zin)   z_q   <= z_d;
    end
  end

endmodule

// File: tb/tb_datapath_core.sv
// Directed self-checking bench for datapath_core: transfers, fetch, ALU ops, bus priority, clr.
module tb_datapath_core;

  logic        clk = 1'b0;
  logic        clr;
  logic [15:0] r_out, r_in;
  logic        HIout, LOout, Zhighout, Zlowout, PCout, MDRout;
  logic        HIin, LOin, PCin, IRin, MARin, MDRin, Yin, Zin, Read;
  logic [4:0]  OpCode;
  logic [31:0] Mdatain;
  logic [31:0] BusMuxOut, IRout_q, MARout_q;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  datapath_core dut (
    .clk(clk), .clr(clr),
    .R0out(r_out[0]), .R1out(r_out[1]), .R2out(r_out[2]), .R3out(r_out[3]),
    .R4out(r_out[4]), .R5out(r_out[5]), .R6out(r_out[6]), .R7out(r_out[7]),
    .R8out(r_out[8]), .R9out(r_out[9]), .R10out(r_out[10]), .R11out(r_out[11]),
    .R12out(r_out[12]), .R13out(r_out[13]), .R14out(r_out[14]), .R15out(r_out[15]),
    .HIout(HIout), .LOout(LOout), .Zhighout(Zhighout), .Zlowout(Zlowout),
    .PCout(PCout), .MDRout(MDRout),
    .R0in(r_in[0]), .R1in(r_in[1]), .R2in(r_in[2]), .R3in(r_in[3]),
    .R4in(r_in[4]), .R5in(r_in[5]), .R6in(r_in[6]), .R7in(r_in[7]),
    .R8in(r_in[8]), .R9in(r_in[9]), .R10in(r_in[10]), .R11in(r_in[11]),
    .R12in(r_in[12]), .R13in(r_in[13]), .R14in(r_in[14]), .R15in(r_in[15]),
    .HIin(HIin), .LOin(LOin), .PCin(PCin), .IRin(IRin), .MARin(MARin),
    .MDRin(MDRin), .Yin(Yin), .Zin(Zin),
    .Read(Read), .OpCode(OpCode), .Mdatain(Mdatain),
    .BusMuxOut(BusMuxOut), .IRout_q(IRout_q), .MARout_q(MARout_q)
  );

  typedef struct {
    logic [31:0] y;
    logic [31:0] b;
    logic [4:0]  op;
    logic [63:0] z;
  } vec_t;

  task automatic idle();
    clr = 0; r_out = '0; r_in = '0;
    HIout = 0; LOout = 0; Zhighout = 0; Zlowout = 0; PCout = 0; MDRout = 0;
    HIin = 0; LOin = 0; PCin = 0; IRin = 0; MARin = 0; MDRin = 0; Yin = 0; Zin = 0;
    Read = 0; OpCode = '0; Mdatain = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Source index: 0..15 = Rn, 16 HI, 17 LO, 18 Zhigh, 19 Zlow, 20 PC, 21 MDR.
  task automatic set_src(input int s, input logic v);
    if (s < 16) r_out[s] = v;
    else case (s)
      16: HIout = v;
      17: LOout = v;
      18: Zhighout = v;
      19: Zlowout = v;
      20: PCout = v;
      default: MDRout = v;
    endcase
  endtask

  task automatic read_src(input int s, output logic [31:0] v);
    idle();
    set_src(s, 1'b1);
    #1 v = BusMuxOut;
    set_src(s, 1'b0);
    #1;
  endtask

  task automatic load_mdr(input logic [31:0] v);
    idle();
    Read = 1; MDRin = 1; Mdatain = v;
    tick();
    idle();
  endtask

  task automatic load_reg(input int n, input logic [31:0] v);
    load_mdr(v);
    MDRout = 1; r_in[n] = 1;
    tick();
    idle();
  endtask

  // Y is only visible through the ALU: OR with an idle bus copies Y into Z.
  task automatic read_y(output logic [31:0] v);
    idle();
    Zin = 1; OpCode = 5'd0;
    tick();
    read_src(19, v);
  endtask

  task automatic test_reset();
    logic [31:0] v;
    idle();
    clr = 1;
    tick();
    idle();
    #1;
    total++; if (BusMuxOut !== 32'h0) begin bad++; $display("FAIL reset_bus got=%h exp=0", BusMuxOut); end
    total++; if (IRout_q !== 32'h0) begin bad++; $display("FAIL reset_ir got=%h exp=0", IRout_q); end
    total++; if (MARout_q !== 32'h0) begin bad++; $display("FAIL reset_mar got=%h exp=0", MARout_q); end
    for (int s = 0; s < 22; s++) begin
      read_src(s, v);
      total++; if (v !== 32'h0) begin bad++; $display("FAIL reset_src%0d got=%h exp=0", s, v); end
    end
  endtask

  task automatic test_mem_load();
    int          regs [3] = '{2, 3, 1};
    logic [31:0] vals [3] = '{32'h000000AA, 32'h0000003F, 32'h00000018};
    logic [31:0] v;
    for (int i = 0; i < 3; i++) begin
      load_mdr(vals[i]);
      MDRout = 1; r_in[regs[i]] = 1;
      #1;
      total++; if (BusMuxOut !== vals[i]) begin bad++; $display("FAIL memload_bus R%0d got=%h exp=%h", regs[i], BusMuxOut, vals[i]); end
      tick();
      idle();
    end
    for (int i = 0; i < 3; i++) begin
      read_src(regs[i], v);
      total++; if (v !== vals[i]) begin bad++; $display("FAIL memload_hold R%0d got=%h exp=%h", regs[i], v, vals[i]); end
    end
  endtask

  task automatic test_fetch();
    logic [31:0] v;
    idle();
    PCout = 1; MARin = 1; Zin = 1; OpCode = 5'd12;
    tick();
    idle();
    Zlowout = 1; PCin = 1; Read = 1; MDRin = 1; Mdatain = 32'h28918000;
    #1;
    total++; if (BusMuxOut !== 32'h1) begin bad++; $display("FAIL fetch_inc got=%h exp=1", BusMuxOut); end
    tick();
    idle();
    MDRout = 1; IRin = 1;
    tick();
    idle();
    #1;
    total++; if (MARout_q !== 32'h0) begin bad++; $display("FAIL fetch_mar got=%h exp=0", MARout_q); end
    total++; if (IRout_q !== 32'h28918000) begin bad++; $display("FAIL fetch_ir got=%h exp=28918000", IRout_q); end
    read_src(20, v);
    total++; if (v !== 32'h1) begin bad++; $display("FAIL fetch_pc got=%h exp=1", v); end
  endtask

  task automatic test_logic();
    logic [4:0]  ops [2] = '{5'd0, 5'd1};
    logic [31:0] exp [2] = '{32'h000000BF, 32'h0000002A};
    logic [31:0] v;
    for (int i = 0; i < 2; i++) begin
      idle(); r_out[2] = 1; Yin = 1; tick();
      idle(); r_out[3] = 1; Zin = 1; OpCode = ops[i]; tick();
      idle(); Zlowout = 1; r_in[1] = 1; tick();
      read_src(1, v);
      total++; if (v !== exp[i]) begin bad++; $display("FAIL logic_op%0d got=%h exp=%h", ops[i], v, exp[i]); end
    end
  endtask

  task automatic test_alu();
    vec_t        t [21];
    logic [31:0] lo, hi;
    t = '{
      '{32'h000000AA, 32'h0000003F, 5'd0,  64'h00000000_000000BF},
      '{32'h000000AA, 32'h0000003F, 5'd1,  64'h00000000_0000002A},
      '{32'h7FFFFFFF, 32'h00000001, 5'd2,  64'h00000000_80000000},
      '{32'hFFFFFFFF, 32'h00000002, 5'd2,  64'h00000000_00000001},
      '{32'h00000003, 32'h00000005, 5'd3,  64'h00000000_FFFFFFFE},
      '{32'h80000000, 32'h00000004, 5'd4,  64'h00000000_08000000},
      '{32'h80000000, 32'h00000004, 5'd5,  64'h00000000_F8000000},
      '{32'h00000001, 32'h00000021, 5'd6,  64'h00000000_00000002},
      '{32'h00000001, 32'h0000001F, 5'd6,  64'h00000000_80000000},
      '{32'h00000001, 32'h00000001, 5'd7,  64'h00000000_80000000},
      '{32'h12345678, 32'h00000000, 5'd7,  64'h00000000_12345678},
      '{32'h80000001, 32'h00000004, 5'd8,  64'h00000000_00000018},
      '{32'hFFFFFFFE, 32'h00000003, 5'd9,  64'hFFFFFFFF_FFFFFFFA},
      '{32'h00010000, 32'h00010000, 5'd9,  64'h00000001_00000000},
      '{32'h00000007, 32'hFFFFFFFE, 5'd10, 64'h00000001_FFFFFFFD},
      '{32'hFFFFFFF9, 32'h00000002, 5'd10, 64'hFFFFFFFF_FFFFFFFD},
      '{32'h00000007, 32'h00000000, 5'd10, 64'h00000000_00000000},
      '{32'h00001234, 32'h00000005, 5'd11, 64'h00000000_FFFFFFFB},
      '{32'h00001234, 32'hFFFFFFFF, 5'd12, 64'h00000000_00000000},
      '{32'h00000000, 32'h0F0F0F0F, 5'd13, 64'h00000000_F0F0F0F0},
      '{32'hFFFFFFFF, 32'hFFFFFFFF, 5'd20, 64'h00000000_00000000}
    };
    for (int i = 0; i < 21; i++) begin
      load_mdr(t[i].y);
      MDRout = 1; Yin = 1; tick();
      load_mdr(t[i].b);
      MDRout = 1; Zin = 1; OpCode = t[i].op; tick();
      read_src(18, hi);
      read_src(19, lo);
      total++;
      if ({hi, lo} !== t[i].z) begin
        bad++;
        $display("FAIL alu_vec%0d op=%0d got=%h exp=%h", i, t[i].op, {hi, lo}, t[i].z);
      end
    end
  endtask

  task automatic test_same_cycle();
    logic [31:0] v;
    idle(); r_out[2] = 1; r_in[2] = 1; Yin = 1; tick();
    read_src(2, v);
    total++; if (v !== 32'hAA) begin bad++; $display("FAIL same_r2 got=%h exp=aa", v); end
    read_y(v);
    total++; if (v !== 32'hAA) begin bad++; $display("FAIL same_y got=%h exp=aa", v); end
    load_reg(5, 32'h55);
    r_in[5] = 1; tick(); idle();
    read_src(5, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL idle_bus_r5 got=%h exp=0", v); end
  endtask

  task automatic test_priority();
    load_reg(15, 32'h99);
    load_mdr(32'h11); MDRout = 1; HIin = 1; tick();
    load_mdr(32'h22); MDRout = 1; LOin = 1; tick();
    idle(); r_out[1] = 1; r_out[3] = 1; #1;
    total++; if (BusMuxOut !== 32'h2A) begin bad++; $display("FAIL prio_r1_r3 got=%h exp=2a", BusMuxOut); end
    idle(); r_out[15] = 1; HIout = 1; #1;
    total++; if (BusMuxOut !== 32'h99) begin bad++; $display("FAIL prio_r15_hi got=%h exp=99", BusMuxOut); end
    idle(); HIout = 1; LOout = 1; MDRout = 1; #1;
    total++; if (BusMuxOut !== 32'h11) begin bad++; $display("FAIL prio_hi_lo got=%h exp=11", BusMuxOut); end
    idle(); PCout = 1; MDRout = 1; #1;
    total++; if (BusMuxOut !== 32'h1) begin bad++; $display("FAIL prio_pc_mdr got=%h exp=1", BusMuxOut); end
    idle();
  endtask

  task automatic test_glitch();
    logic [31:0] v;
    load_mdr(32'h66);
    MDRout = 1;
    #2 r_in[6] = 1;
    #2 r_in[6] = 0;
    tick();
    read_src(6, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL glitch_r6 got=%h exp=0", v); end
  endtask

  task automatic test_clr();
    logic [31:0] v;
    load_mdr(32'hDEAD0001);
    MDRout = 1; MARin = 1; HIin = 1; LOin = 1; PCin = 1; Yin = 1; r_in[4] = 1; tick();
    idle(); MDRout = 1; Zin = 1; OpCode = 5'd12; tick();
    idle(); clr = 1; MDRout = 1; r_in[1] = 1; Zin = 1; OpCode = 5'd12;
    tick();
    idle(); #1;
    total++; if (IRout_q !== 32'h0) begin bad++; $display("FAIL clr_ir got=%h exp=0", IRout_q); end
    total++; if (MARout_q !== 32'h0) begin bad++; $display("FAIL clr_mar got=%h exp=0", MARout_q); end
    for (int s = 0; s < 22; s++) begin
      read_src(s, v);
      total++; if (v !== 32'h0) begin bad++; $display("FAIL clr_src%0d got=%h exp=0", s, v); end
    end
    read_y(v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL clr_y got=%h exp=0", v); end
    load_reg(1, 32'h77);
    read_src(1, v);
    total++; if (v !== 32'h77) begin bad++; $display("FAIL clr_after_r1 got=%h exp=77", v); end
  endtask

  initial begin
    idle();
    test_reset();
    test_mem_load();
    test_fetch();
    test_logic();
    test_alu();
    test_same_cycle();
    test_priority();
    test_glitch();
    test_clr();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
